// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin arbiter that lets two clients share one
// multi-cycle add/sub core. Each client holds req with stable operands
// until it sees a one-cycle ready pulse; the result stays on c<n>_res
// until that client's next completion.
module addsub_arbiter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         c0_req,
    input  logic         c0_mode,
    input  logic [W-1:0] c0_a,
    input  logic [W-1:0] c0_b,
    output logic         c0_ready,
    output logic [W-1:0] c0_res,
    input  logic         c1_req,
    input  logic         c1_mode,
    input  logic [W-1:0] c1_a,
    input  logic [W-1:0] c1_b,
    output logic         c1_ready,
    output logic [W-1:0] c1_res,
    output logic         core_start_o,
    output logic         core_mode_o,
    output logic [W-1:0] core_a_o,
    output logic [W-1:0] core_b_o,
    input  logic         core_busy_i,
    input  logic [W-1:0] core_res_i,
    output logic         busy_o,
    output logic         grant_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           w_grant_en;
    logic           w_grant_idx;
    logic           w_done;

    logic           r_start;
    logic           r_mode;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic           r_grant;
    logic           r_last;
    logic           r_rdy0;
    logic           r_rdy1;
    logic [W-1:0]   r_res0;
    logic [W-1:0]   r_res1;

    // Busy is only sampled in WAIT; LAUNCH gives a late-rising busy time to appear.
    assign w_done = (r_state == S_WAIT) && !core_busy_i;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and arbitration: on a tie the client that was not granted last wins.
    always_comb begin
        w_next      = r_state;
        w_grant_en  = 1'b0;
        w_grant_idx = r_grant;
        case (r_state)
            S_IDLE: begin
                if (c0_req || c1_req) begin
                    w_grant_en  = 1'b1;
                    w_grant_idx = (c0_req && c1_req) ? ~r_last : c1_req;
                    w_next      = S_LAUNCH;
                end
            end
            S_LAUNCH: w_next = S_WAIT;
            S_WAIT:   if (!core_busy_i) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Grant bookkeeping, operand latch and start pulse; operands are frozen until the next grant.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_start <= 1'b0;
            r_mode  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_start <= w_grant_en;
            if (w_grant_en) begin
                r_grant <= w_grant_idx;
                r_last  <= w_grant_idx;
                r_mode  <= w_grant_idx ? c1_mode : c0_mode;
                r_a     <= w_grant_idx ? c1_a    : c0_a;
                r_b     <= w_grant_idx ? c1_b    : c0_b;
            end
        end
    end

    // Completion: only the granted client sees ready and gets its result register updated.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rdy0 <= 1'b0;
            r_rdy1 <= 1'b0;
            r_res0 <= '0;
            r_res1 <= '0;
        end else begin
            r_rdy0 <= w_done && !r_grant;
            r_rdy1 <= w_done &&  r_grant;
            if (w_done && !r_grant) r_res0 <= core_res_i;
            if (w_done &&  r_grant) r_res1 <= core_res_i;
        end
    end

    assign c0_ready     = r_rdy0;
    assign c1_ready     = r_rdy1;
    assign c0_res       = r_res0;
    assign c1_res       = r_res1;
    assign core_start_o = r_start;
    assign core_mode_o  = r_mode;
    assign core_a_o     = r_a;
    assign core_b_o     = r_b;
    assign busy_o       = (r_state != S_IDLE);
    assign grant_o      = r_grant;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: a behavioural add/sub core with programmable
// busy length, clients driven at the falling edge, and a reference model
// of round-robin order and modulo-2^W arithmetic.
module tb_addsub_arbiter;
    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         c0_req, c0_mode, c1_req, c1_mode;
    logic [W-1:0] c0_a, c0_b, c1_a, c1_b;
    logic         c0_ready, c1_ready;
    logic [W-1:0] c0_res, c1_res;
    logic         core_start_o, core_mode_o, core_busy_i, busy_o, grant_o;
    logic [W-1:0] core_a_o, core_b_o, core_res_i;

    int n_tests = 0;
    int n_fail  = 0;

    // core model state
    int slow_len = 0;
    int busy_cnt = 0;

    // monitor state
    int   n_starts = 0;
    logic prev_start = 1'b0;
    logic consec_start = 1'b0;
    logic both_rdy = 1'b0;

    // reference model: last granted client and operands per client
    int           m_last;
    logic         op_m [2];
    logic [W-1:0] op_a [2];
    logic [W-1:0] op_b [2];

    always #5 clk_i = ~clk_i;

    addsub_arbiter #(.W(W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .c0_req(c0_req), .c0_mode(c0_mode), .c0_a(c0_a), .c0_b(c0_b),
        .c0_ready(c0_ready), .c0_res(c0_res),
        .c1_req(c1_req), .c1_mode(c1_mode), .c1_a(c1_a), .c1_b(c1_b),
        .c1_ready(c1_ready), .c1_res(c1_res),
        .core_start_o(core_start_o), .core_mode_o(core_mode_o),
        .core_a_o(core_a_o), .core_b_o(core_b_o),
        .core_busy_i(core_busy_i), .core_res_i(core_res_i),
        .busy_o(busy_o), .grant_o(grant_o)
    );

    // Behavioural core: busy rises the cycle after start for slow_len cycles.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)                         busy_cnt <= 0;
        else if (core_start_o && slow_len > 0) busy_cnt <= slow_len;
        else if (busy_cnt > 0)              busy_cnt <= busy_cnt - 1;
    end
    assign core_busy_i = (busy_cnt > 0);
    assign core_res_i  = core_mode_o ? W'(core_a_o + core_b_o) : W'(core_a_o - core_b_o);

    always @(negedge clk_i) begin
        if (c0_ready && c1_ready) both_rdy = 1'b1;
        if (core_start_o && prev_start) consec_start = 1'b1;
        if (core_start_o) n_starts++;
        prev_start = core_start_o;
    end

    function automatic logic [W-1:0] ref_res(input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned s;
        s = m ? (int'(a) + int'(b)) : (int'(a) + 256 - int'(b));
        return W'(s % 256);
    endfunction

    task automatic set_client(input int idx, input logic m, input logic [W-1:0] a, input logic [W-1:0] b);
        op_m[idx] = m; op_a[idx] = a; op_b[idx] = b;
        if (idx == 0) begin c0_mode = m; c0_a = a; c0_b = b; c0_req = 1'b1; end
        else          begin c1_mode = m; c1_a = a; c1_b = b; c1_req = 1'b1; end
    endtask

    // Wait (bounded) for a ready pulse; the served client drops req right away.
    task automatic serve(input int maxc, output int who, output int cyc, output logic [W-1:0] res);
        who = -1; cyc = 0; res = '0;
        while (who < 0 && cyc < maxc) begin
            @(negedge clk_i);
            cyc++;
            if (c0_ready)      begin who = 0; res = c0_res; c0_req = 1'b0; end
            else if (c1_ready) begin who = 1; res = c1_res; c1_req = 1'b0; end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        c0_req = 0; c1_req = 0; c0_mode = 0; c1_mode = 0;
        c0_a = 0; c0_b = 0; c1_a = 0; c1_b = 0;
        repeat (2) @(negedge clk_i);
        n_tests++;
        if ({c0_ready, c1_ready, core_start_o, core_mode_o, busy_o, grant_o} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctl got %b want 000000", {c0_ready, c1_ready, core_start_o, core_mode_o, busy_o, grant_o});
        end
        n_tests++;
        if ({c0_res, c1_res, core_a_o, core_b_o} !== '0) begin
            n_fail++; $display("FAIL reset_data got %h want 0", {c0_res, c1_res, core_a_o, core_b_o});
        end
        rst_i = 1'b1;
        m_last = 1;
        repeat (2) @(negedge clk_i);
        n_tests++;
        if ({busy_o, core_start_o} !== 2'b0) begin
            n_fail++; $display("FAIL idle_no_req got %b want 00", {busy_o, core_start_o});
        end
    endtask

    task automatic test_single_add();
        int s0;
        s0 = n_starts;
        set_client(0, 1'b1, 8'd20, 8'd7);
        @(negedge clk_i);              // after E0
        n_tests++;
        if ({core_start_o, busy_o, grant_o, core_mode_o} !== 4'b1101 || core_a_o !== 8'd20 || core_b_o !== 8'd7) begin
            n_fail++; $display("FAIL add_launch got start/busy/grant/mode=%b a=%0d b=%0d want 1101 20 7",
                               {core_start_o, busy_o, grant_o, core_mode_o}, core_a_o, core_b_o);
        end
        c0_a = 8'd99;                  // change while granted: must be ignored
        @(negedge clk_i);              // after E1
        n_tests++;
        if (core_start_o !== 1'b0 || core_a_o !== 8'd20) begin
            n_fail++; $display("FAIL add_hold got start=%b a=%0d want 0 20", core_start_o, core_a_o);
        end
        @(negedge clk_i);              // after E2
        n_tests++;
        if (c0_ready !== 1'b1 || c1_ready !== 1'b0 || c0_res !== ref_res(1'b1, 8'd20, 8'd7)) begin
            n_fail++; $display("FAIL add_ready got rdy0=%b rdy1=%b res=%0d want 1 0 27", c0_ready, c1_ready, c0_res);
        end
        c0_req = 1'b0;
        @(negedge clk_i);              // after E3
        n_tests++;
        if (c0_ready !== 1'b0 || busy_o !== 1'b0 || c0_res !== 8'd27) begin
            n_fail++; $display("FAIL add_end got rdy0=%b busy=%b res=%0d want 0 0 27", c0_ready, busy_o, c0_res);
        end
        n_tests++;
        if (n_starts - s0 !== 1) begin
            n_fail++; $display("FAIL add_starts got %0d want 1", n_starts - s0);
        end
        m_last = 0;
    endtask

    task automatic test_sub_wrap();
        set_client(1, 1'b0, 8'd3, 8'd5);
        @(negedge clk_i);
        n_tests++;
        if (grant_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL sub_grant got grant=%b busy=%b want 1 1", grant_o, busy_o);
        end
        @(negedge clk_i);
        n_tests++;
        if (busy_o !== 1'b1) begin
            n_fail++; $display("FAIL sub_busy_wait got %b want 1", busy_o);
        end
        @(negedge clk_i);
        n_tests++;
        if (c1_ready !== 1'b1 || c0_ready !== 1'b0 || c1_res !== ref_res(1'b0, 8'd3, 8'd5) || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL sub_ready got rdy1=%b rdy0=%b res=%0d busy=%b want 1 0 254 1", c1_ready, c0_ready, c1_res, busy_o);
        end
        c1_req = 1'b0;
        @(negedge clk_i);
        n_tests++;
        if (busy_o !== 1'b0 || c1_ready !== 1'b0 || c0_res !== 8'd27) begin
            n_fail++; $display("FAIL sub_end got busy=%b rdy1=%b c0_res=%0d want 0 0 27", busy_o, c1_ready, c0_res);
        end
        m_last = 1;
    endtask

    task automatic test_simultaneous();
        int who, cyc;
        logic [W-1:0] res;
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        m_last = 1;
        set_client(0, 1'b1, 8'd1, 8'd1);
        set_client(1, 1'b0, 8'd9, 8'd4);
        serve(20, who, cyc, res);
        n_tests++;
        if (who !== (1 - m_last) || res !== ref_res(op_m[0], op_a[0], op_b[0])) begin
            n_fail++; $display("FAIL simul_first got who=%0d res=%0d want 0 2", who, res);
        end
        m_last = 0;
        serve(20, who, cyc, res);
        n_tests++;
        if (who !== 1 || res !== ref_res(op_m[1], op_a[1], op_b[1]) || c0_res !== 8'd2) begin
            n_fail++; $display("FAIL simul_second got who=%0d res=%0d c0_res=%0d want 1 5 2", who, res, c0_res);
        end
        m_last = 1;
    endtask

    task automatic test_fairness();
        int who, cyc, exp_who;
        logic [W-1:0] res;
        both_rdy = 1'b0;
        @(negedge clk_i);
        set_client(0, 1'($urandom_range(1)), W'($urandom), W'($urandom));
        set_client(1, 1'($urandom_range(1)), W'($urandom), W'($urandom));
        for (int k = 0; k < 6; k++) begin
            exp_who = 1 - m_last;
            serve(20, who, cyc, res);
            n_tests++;
            if (who !== exp_who || (who >= 0 && res !== ref_res(op_m[exp_who], op_a[exp_who], op_b[exp_who]))) begin
                n_fail++; $display("FAIL fair_op%0d got who=%0d res=%0d want who=%0d res=%0d", k, who, res, exp_who,
                                   ref_res(op_m[exp_who], op_a[exp_who], op_b[exp_who]));
            end
            m_last = exp_who;
            @(negedge clk_i);
            if (k < 4) set_client(exp_who, 1'($urandom_range(1)), W'($urandom), W'($urandom));
        end
        n_tests++;
        if (both_rdy !== 1'b0 || consec_start !== 1'b0) begin
            n_fail++; $display("FAIL fair_excl got both_ready=%b consec_start=%b want 0 0", both_rdy, consec_start);
        end
    endtask

    task automatic test_back_to_back();
        int who, cyc;
        logic [W-1:0] res, c1_keep;
        c1_keep = c1_res;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            set_client(0, 1'($urandom_range(1)), W'($urandom), W'($urandom));
            serve(20, who, cyc, res);
            n_tests++;
            if (who !== 0 || cyc !== 3 || res !== ref_res(op_m[0], op_a[0], op_b[0]) || c1_res !== c1_keep) begin
                n_fail++; $display("FAIL b2b_op%0d got who=%0d lat=%0d res=%0d c1_res=%0d want 0 3 %0d %0d", k, who, cyc, res,
                                   c1_res, ref_res(op_m[0], op_a[0], op_b[0]), c1_keep);
            end
        end
        m_last = 0;
    endtask

    task automatic test_slow_core();
        int cyc, busy_fall, rdy_at;
        logic stable, seen_busy;
        logic [W-1:0] la, lb;
        logic lm;
        slow_len = 5;
        @(negedge clk_i);
        set_client(1, 1'($urandom_range(1)), W'($urandom), W'($urandom));
        @(negedge clk_i);
        la = core_a_o; lb = core_b_o; lm = core_mode_o;
        stable = (la === op_a[1]) && (lb === op_b[1]) && (lm === op_m[1]);
        seen_busy = 1'b0; busy_fall = -1; rdy_at = -1; cyc = 1;
        while (rdy_at < 0 && cyc < 30) begin
            @(negedge clk_i);
            cyc++;
            if ({core_a_o, core_b_o, core_mode_o} !== {la, lb, lm}) stable = 1'b0;
            if (core_busy_i) seen_busy = 1'b1;
            else if (seen_busy && busy_fall < 0) busy_fall = cyc;
            if (c1_ready) begin rdy_at = cyc; c1_req = 1'b0; end
        end
        n_tests++;
        if (stable !== 1'b1 || rdy_at !== busy_fall + 1 || rdy_at !== 8) begin
            n_fail++; $display("FAIL slow_core got stable=%b busy_fall=%0d ready_at=%0d want 1 7 8", stable, busy_fall, rdy_at);
        end
        n_tests++;
        if (c1_res !== ref_res(op_m[1], op_a[1], op_b[1])) begin
            n_fail++; $display("FAIL slow_res got %0d want %0d", c1_res, ref_res(op_m[1], op_a[1], op_b[1]));
        end
        m_last = 1;
    endtask

    task automatic test_reset_midop();
        int who, cyc;
        logic [W-1:0] res;
        slow_len = 5;
        @(negedge clk_i);
        set_client(1, 1'b1, W'($urandom), W'($urandom));
        repeat (4) @(negedge clk_i);
        n_tests++;
        if (busy_o !== 1'b1 || c1_ready !== 1'b0) begin
            n_fail++; $display("FAIL midop_inwait got busy=%b rdy1=%b want 1 0", busy_o, c1_ready);
        end
        rst_i = 1'b0;
        #1;
        n_tests++;
        if ({c0_ready, c1_ready, core_start_o, core_mode_o, busy_o, grant_o, c0_res, c1_res, core_a_o, core_b_o} !== '0) begin
            n_fail++; $display("FAIL midop_reset got nonzero outputs busy=%b a=%0d c1_res=%0d want 0", busy_o, core_a_o, c1_res);
        end
        slow_len = 0;
        set_client(0, 1'b1, W'($urandom), W'($urandom));
        @(negedge clk_i);
        rst_i = 1'b1;
        m_last = 1;
        serve(20, who, cyc, res);
        n_tests++;
        if (who !== 0 || res !== ref_res(op_m[0], op_a[0], op_b[0])) begin
            n_fail++; $display("FAIL midop_first got who=%0d res=%0d want 0 %0d", who, res, ref_res(op_m[0], op_a[0], op_b[0]));
        end
        serve(20, who, cyc, res);
        n_tests++;
        if (who !== 1 || res !== ref_res(op_m[1], op_a[1], op_b[1])) begin
            n_fail++; $display("FAIL midop_second got who=%0d res=%0d want 1 %0d", who, res, ref_res(op_m[1], op_a[1], op_b[1]));
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_sub_wrap();
        test_simultaneous();
        test_fairness();
        test_back_to_back();
        test_slow_core();
        test_reset_midop();
        repeat (3) @(negedge clk_i);
        n_tests++;
        if (consec_start !== 1'b0 || both_rdy !== 1'b0) begin
            n_fail++; $display("FAIL global_excl got consec_start=%b both_ready=%b want 0 0", consec_start, both_rdy);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/addsub_arbiter.md
Name: addsub_arbiter

Overview:
- Shares one multi-cycle add/sub core between two function units (e.g. cubic root and a second arithmetic unit).
- Each client uses a level req / one-cycle ready handshake: it holds req high with operands stable until it sees ready.
- The arbiter grants round-robin, launches the core with a start pulse and waits for core busy to fall.
- It returns the result to the granted client only.

Parameters:
W, 8, operand/result width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous active-low reset
c0_req  in  1  client 0 request, level, held until c0_ready seen
c0_mode  in  1  client 0 op: 0 = a-b, 1 = a+b
c0_a  in  W  client 0 operand a
c0_b  in  W  client 0 operand b
c0_ready  out  1  client 0 one-cycle completion pulse
c0_res  out  W  client 0 result, held until client 0's next completion
c1_req, c1_mode, c1_a, c1_b, c1_ready, c1_res  same as client 0, for client 1
core_start_o  out  1  one-cycle start pulse to the core
core_mode_o  out  1  latched op mode
core_a_o  out  W  latched operand a
core_b_o  out  W  latched operand b
core_busy_i  in  1  core busy; may rise up to one cycle after start
core_res_i  in  W  core result, valid when busy low after start
busy_o  out  1  high when state != IDLE
grant_o  out  1  index of the current/last granted client

Behaviour:
- Reset (asynchronous, any state): state=IDLE; all outputs 0; last-grant pointer=1, so client 0 wins the first tie. Any operation in flight is abandoned, with no ready pulse.
- States: IDLE, LAUNCH, WAIT, RESP. Encoding is free.
- IDLE:
  - No req: stay.
  - Exactly one req: grant that client.
  - Both reqs: grant the client != last-grant pointer.
  - On grant: latch mode/a/b into core_*_o; set grant_o and the pointer to the granted index; core_start_o<=1; go to LAUNCH.
- LAUNCH: core_start_o<=0; go to WAIT. core_busy_i is not sampled here (covers late busy rise).
- WAIT:
  - core_busy_i=1: stay; core_*_o held constant.
  - core_busy_i=0: capture core_res_i into c<grant>_res; c<grant>_ready<=1; go to RESP.
- RESP: c<grant>_ready<=0; go to IDLE. req is not sampled in RESP. The client drops req on the edge it samples ready, so the same request is never granted twice.
- Minimum latency, with a core that never raises busy:
  - req sampled at edge E0, start high E0–E1.
  - ready high between E2 and E3; result visible on c_res from E2.
  - Next grant earliest at E4 (first IDLE sampling edge after RESP).
- Ungranted client: its ready stays 0 and its res is unchanged; its req is held and served after the current op completes.
- Back-to-back from one client with the other idle: served each time, with no starvation penalty.
- Both reqs continuously high: grants strictly alternate 0,1,0,1…
- Client operand changes while granted are ignored (operands latched at grant).
- Arithmetic is done by the core: W-bit modulo 2^W. The arbiter only forwards mode and result, with no width change.
- Only one c*_ready may be high in any cycle. core_start_o is never high in consecutive cycles.

Test Plan:
- Single add: c0 req, mode=1, a=8'd20, b=8'd7; 1-cycle core -> one core_start pulse; c0_ready one pulse 3 edges after req; c0_res=27; c1_ready stays 0.
- Sub wrap: c1 req, mode=0, a=3, b=5 -> c1_res=8'd254; grant_o=1; busy_o high from E0 to RESP exit.
- Simultaneous from reset: c0 (a=1,b=1,add) and c1 (a=9,b=4,sub) asserted the same cycle, each held until its ready -> c0 served first (res 2), then c1 (res 5); c0_res still 2 after c1 completes.
- Fairness: both reqs re-asserted immediately after every ready for 6 ops -> grant sequence 0,1,0,1,0,1; no cycle with both readys high.
- Slow core: busy rises the cycle after start and stays high 5 cycles -> core_a/b/mode stable throughout; ready exactly 1 cycle after busy falls.
- Reset mid-op: rst_i low while in WAIT -> all outputs 0 immediately; after release, a pending c1 req is granted before c0 on a tie only if the pointer dictates (pointer=1, so c0 wins).
